// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load/store per request over a req/ack data bus,
// producing byte enables, lane-replicated store data and extended load data.
module load_store_unit #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic                accept_err;
    logic [1:0]          off;
    logic [3:0]          lane_be;
    logic [31:0]         lane_wdata;
    logic [31:0]         shifted;
    logic [31:0]         load_data;
    logic                timeout_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    // Stores only allow B/H/W; halfwords need even and words need 4-byte alignment.
    always_comb begin
        accept_err = 1'b0;
        case (req_funct3)
            3'b000:         accept_err = 1'b0;
            3'b001, 3'b101: accept_err = req_addr[0] | (req_we & req_funct3[2]);
            3'b010:         accept_err = |req_addr[1:0];
            3'b100:         accept_err = req_we;
            default:        accept_err = 1'b1;
        endcase
    end

    always_comb begin
        off        = addr_q[1:0];
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                lane_be    = 4'b0001 << off;
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
            end
        endcase
        shifted = mem_rdata >> {off, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
        timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = accept_err;
                    state_d  = accept_err ? RESP : BUS;
                end
            end
            BUS: begin
                // An ack arriving on the timeout cycle still completes the access.
                if (mem_ack) begin
                    rdata_d = we_q ? 32'd0 : load_data;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_CYC != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every output is forced low while reset is asserted, whatever the state.
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        if (!rst) begin
            req_ready = (state_q == IDLE);
            busy      = (state_q != IDLE);
            if (state_q == BUS) begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata = lane_wdata;
                mem_be    = lane_be;
            end
            if (state_q == RESP) begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, extended loads, alignment/funct3
// errors, bus timeout and reset mid-transfer.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_total = 0;
    int n_pass  = 0;
    int req_cycles;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Outputs are sampled and inputs driven 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Presents one request for a single cycle; afterwards the request has been accepted.
    task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        tick();
        req_valid  = 1'b0;
    endtask

    // Load with ack in the first bus cycle; checks be/addr then the extended result.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rword, input logic [3:0] exp_be,
                            input logic [31:0] exp_rdata);
        apply_stimulus(1'b0, f3, addr, 32'h0);
        check_output({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        check_output({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_output({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        check_output({tag, "_mem_be"}, 32'(mem_be), 32'(exp_be));
        mem_ack   = 1'b1;
        mem_rdata = rword;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check_output({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check_output({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check_output({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
        tick();
        check_output({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        check_output({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    // Request rejected at accept: one-cycle error response with no bus activity.
    task automatic run_error(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
        apply_stimulus(we, f3, addr, 32'h1234_5678);
        check_output({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        check_output({tag, "_resp_err"}, 32'(resp_err), 32'd1);
        check_output({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check_output({tag, "_no_mem_req"}, 32'(mem_req), 32'd0);
        tick();
        check_output({tag, "_resp_drop"}, 32'(resp_valid), 32'd0);
        check_output({tag, "_no_mem_req2"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        tick();
        check_output("idle_req_ready", 32'(req_ready), 32'd1);
        check_output("idle_busy", 32'(busy), 32'd0);

        // SW 0x104 with ack three cycles after mem_req rises
        apply_stimulus(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
        check_output("sw_mem_req", 32'(mem_req), 32'd1);
        check_output("sw_mem_we", 32'(mem_we), 32'd1);
        check_output("sw_mem_addr", mem_addr, 32'h0000_0104);
        check_output("sw_mem_be", 32'(mem_be), 32'hF);
        check_output("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check_output("sw_busy", 32'(busy), 32'd1);
        check_output("sw_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        tick();
        check_output("sw_mem_req_held", 32'(mem_req), 32'd1);
        check_output("sw_mem_wdata_held", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_output("sw_resp_valid", 32'(resp_valid), 32'd1);
        check_output("sw_resp_err", 32'(resp_err), 32'd0);
        check_output("sw_resp_rdata", resp_rdata, 32'd0);
        check_output("sw_mem_req_low", 32'(mem_req), 32'd0);
        tick();
        check_output("sw_resp_drop", 32'(resp_valid), 32'd0);
        check_output("sw_ready_back", 32'(req_ready), 32'd1);

        // Extended loads from 0x80FF1234
        run_load("lb",  3'b000, 32'h0000_0203, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80);
        run_load("lbu", 3'b100, 32'h0000_0203, 32'h80FF_1234, 4'b1000, 32'h0000_0080);
        run_load("lhu", 3'b101, 32'h0000_0202, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
        run_load("lh",  3'b001, 32'h0000_0200, 32'h80FF_8234, 4'b0011, 32'hFFFF_8234);
        run_load("lb1", 3'b000, 32'h0000_0201, 32'h80FF_1234, 4'b0010, 32'h0000_0012);

        // Rejected requests
        run_error("lh_misal", 1'b0, 3'b001, 32'h0000_0201);
        run_error("f3_011",   1'b0, 3'b011, 32'h0000_0200);
        run_error("sw_misal", 1'b1, 3'b010, 32'h0000_0202);
        run_error("sbu",      1'b1, 3'b100, 32'h0000_0200);

        // SB 0x12
        apply_stimulus(1'b1, 3'b000, 32'h0000_0012, 32'h0000_00AB);
        check_output("sb_mem_addr", mem_addr, 32'h0000_0010);
        check_output("sb_mem_be", 32'(mem_be), 32'b0100);
        check_output("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_output("sb_resp_valid", 32'(resp_valid), 32'd1);
        check_output("sb_resp_err", 32'(resp_err), 32'd0);
        tick();

        // SH 0x0E: upper half lanes
        apply_stimulus(1'b1, 3'b001, 32'h0000_000E, 32'h1111_C0DE);
        check_output("sh_mem_be", 32'(mem_be), 32'b1100);
        check_output("sh_mem_wdata", mem_wdata, 32'hC0DE_C0DE);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_output("sh_resp_valid", 32'(resp_valid), 32'd1);
        tick();

        // Timeout: no ack, mem_req must stay high exactly 8 cycles
        apply_stimulus(1'b0, 3'b010, 32'h0000_0300, 32'h0);
        req_cycles = 0;
        while (mem_req && req_cycles < 20) begin
            req_cycles++;
            tick();
        end
        check_output("to_req_cycles", 32'(req_cycles), 32'd8);
        check_output("to_resp_valid", 32'(resp_valid), 32'd1);
        check_output("to_resp_err", 32'(resp_err), 32'd1);
        check_output("to_resp_rdata", resp_rdata, 32'd0);
        tick();
        check_output("to_ready_back", 32'(req_ready), 32'd1);
        check_output("to_busy", 32'(busy), 32'd0);

        // Reset in the middle of a bus access, then a late ack
        apply_stimulus(1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        check_output("rb_in_bus", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check_output("rb_rst_mem_req", 32'(mem_req), 32'd0);
        check_output("rb_rst_busy", 32'(busy), 32'd0);
        tick();
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check_output("rb_no_resp", 32'(resp_valid), 32'd0);
        check_output("rb_mem_req", 32'(mem_req), 32'd0);
        check_output("rb_req_ready", 32'(req_ready), 32'd1);
        tick();
        check_output("rb_no_resp2", 32'(resp_valid), 32'd0);
        run_load("lw_after_rst", 3'b010, 32'h0000_0400, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
